// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with a 2-flop input synchroniser and sticky error flags.
// Parity checking is compiled in only when the macro UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rx_in,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rx_sync;
  logic                 armed, stop_idx, frame_bad, par_bit;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 mid, last, final_stop, parity_bad;

  assign mid        = (cnt == MID);
  assign last       = (cnt == LAST);
  assign final_stop = (STOP_BITS == 1) || stop_idx;
  assign parity_bad = PARITY_EN && ((^{shift, par_bit}) != 1'(PARITY_ODD));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      armed       <= 1'b0;
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      stop_idx    <= 1'b0;
      frame_bad   <= 1'b0;
      par_bit     <= 1'b0;
      shift       <= '0;
      ready       <= 1'b0;
      rx_out      <= '0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      if (ready_clr) begin
        ready       <= 1'b0;
        frame_err   <= 1'b0;
        parity_err  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (rx_en) begin
        cnt <= last ? '0 : cnt + CW'(1);
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rx_sync) begin
              armed <= 1'b1;
            end else if (armed) begin
              state     <= START;
              idx       <= '0;
              stop_idx  <= 1'b0;
              frame_bad <= 1'b0;
            end
          end
          START: begin
            // A line that is high again at mid-bit was only a glitch.
            if (mid && rx_sync) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (last) begin
              state <= DATA;
            end
          end
          DATA: begin
            if (mid) shift[idx] <= rx_sync;
            if (last) begin
              if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
          PARITY: begin
            if (mid) par_bit <= rx_sync;
            if (last) state <= STOP;
          end
          STOP: begin
            if (mid) begin
              if (final_stop) begin
                // Delivery takes priority over a coincident ready_clr.
                rx_out      <= shift;
                ready       <= 1'b1;
                frame_err   <= (frame_err & ~ready_clr) | frame_bad | ~rx_sync;
                parity_err  <= (parity_err & ~ready_clr) | parity_bad;
                overrun_err <= (overrun_err | ready) & ~ready_clr;
              end else begin
                frame_bad <= frame_bad | ~rx_sync;
              end
            end
            if (last) begin
              if (final_stop) begin
                state <= IDLE;
                armed <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations checked every cycle against a tick-position frame model.
module tb_uart_rx_param;
  localparam int DB0 = 8, OS0 = 16, SB0 = 1, PO0 = 0;
  localparam int DB1 = 5, OS1 = 16, SB1 = 2, PO1 = 0;
  localparam int DB2 = 9, OS2 = 12, SB2 = 1, PO2 = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, en, rxi, clr;
  logic [2:0] rdy, fe, pe, oe, bsy;
  logic [7:0] out0;
  logic [4:0] out1;
  logic [8:0] out2;

  uart_rx_param #(.DATA_BITS(DB0), .OVERSAMPLE(OS0), .STOP_BITS(SB0), .PARITY_ODD(PO0)) u0 (
    .clk(clk), .reset(rst[0]), .rx_en(en[0]), .rx_in(rxi[0]), .ready_clr(clr[0]),
    .ready(rdy[0]), .rx_out(out0), .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun_err(oe[0]), .busy(bsy[0]));
  uart_rx_param #(.DATA_BITS(DB1), .OVERSAMPLE(OS1), .STOP_BITS(SB1), .PARITY_ODD(PO1)) u1 (
    .clk(clk), .reset(rst[1]), .rx_en(en[1]), .rx_in(rxi[1]), .ready_clr(clr[1]),
    .ready(rdy[1]), .rx_out(out1), .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun_err(oe[1]), .busy(bsy[1]));
  uart_rx_param #(.DATA_BITS(DB2), .OVERSAMPLE(OS2), .STOP_BITS(SB2), .PARITY_ODD(PO2)) u2 (
    .clk(clk), .reset(rst[2]), .rx_en(en[2]), .rx_in(rxi[2]), .ready_clr(clr[2]),
    .ready(rdy[2]), .rx_out(out2), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun_err(oe[2]), .busy(bsy[2]));

  function automatic int f_db(int k); return (k == 0) ? DB0 : (k == 1) ? DB1 : DB2; endfunction
  function automatic int f_os(int k); return (k == 0) ? OS0 : (k == 1) ? OS1 : OS2; endfunction
  function automatic int f_sb(int k); return (k == 0) ? SB0 : (k == 1) ? SB1 : SB2; endfunction
  function automatic bit f_po(int k); return (k == 0) ? PO0[0] : (k == 1) ? PO1[0] : PO2[0]; endfunction
  function automatic logic [8:0] get_out(int k);
    return (k == 0) ? {1'b0, out0} : (k == 1) ? {4'b0, out1} : out2;
  endfunction

  int cyc = 0;
  int rate[3] = '{1, 1, 1};
  int start_cyc[3], rise_cyc[3];
  int n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int k = 0; k < 3; k++) en[k] = ((cyc % rate[k]) == 0);

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[u%0d] cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
  endtask

  // Reference model: a frame is a run of ticks counted from start detection; bit number and
  // phase within the bit follow from that count by division.
  bit         m_h1[3], m_h2[3], m_armed[3], m_inf[3], m_fbad[3], m_par[3];
  int         m_pos[3];
  logic [8:0] m_word[3];
  bit         e_rdy[3], e_fe[3], e_pe[3], e_oe[3];
  logic [8:0] e_out[3];

  task automatic model_step(input int k);
    int dbk, osk, nb, b, ph;
    bit s, deliver, pbad;
    logic [8:0] mask;
    dbk  = f_db(k);
    osk  = f_os(k);
    nb   = 1 + dbk + PEN + f_sb(k);
    mask = 9'((1 << dbk) - 1);
    s    = m_h2[k];
    if (rst[k]) begin
      m_h1[k] = 1; m_h2[k] = 1; m_armed[k] = 0; m_inf[k] = 0;
      e_rdy[k] = 0; e_fe[k] = 0; e_pe[k] = 0; e_oe[k] = 0; e_out[k] = '0;
      return;
    end
    m_h2[k] = m_h1[k];
    m_h1[k] = rxi[k];
    deliver = 0;
    if (en[k]) begin
      if (!m_inf[k]) begin
        if (s) m_armed[k] = 1;
        else if (m_armed[k]) begin m_inf[k] = 1; m_pos[k] = 0; m_fbad[k] = 0; end
      end else begin
        m_pos[k]++;
        b  = (m_pos[k] - 1) / osk;
        ph = (m_pos[k] - 1) % osk;
        if (ph == osk / 2 - 1) begin
          if (b == 0) begin
            if (s) m_inf[k] = 0;
          end else if (b <= dbk) begin
            m_word[k][b-1] = s;
          end else if (PEN == 1 && b == dbk + 1) begin
            m_par[k] = s;
          end else begin
            if (!s) m_fbad[k] = 1;
            if (b == nb - 1) deliver = 1;
          end
        end
        if (m_inf[k] && ph == osk - 1 && b == nb - 1) begin m_inf[k] = 0; m_armed[k] = 0; end
      end
    end
    if (deliver) begin
      pbad     = (PEN == 1) && (((^(m_word[k] & mask)) ^ m_par[k]) != f_po(k));
      e_oe[k]  = (e_oe[k] || e_rdy[k]) && !clr[k];
      e_fe[k]  = (e_fe[k] && !clr[k]) || m_fbad[k];
      e_pe[k]  = (e_pe[k] && !clr[k]) || pbad;
      e_rdy[k] = 1;
      e_out[k] = m_word[k] & mask;
    end else if (clr[k]) begin
      e_rdy[k] = 0; e_fe[k] = 0; e_pe[k] = 0; e_oe[k] = 0;
    end
  endtask

  always @(posedge clk) for (int k = 0; k < 3; k++) model_step(k);

  logic [2:0] rdy_prev = '0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("ready", k, 32'(rdy[k]), 32'(e_rdy[k]));
        chk("rx_out", k, 32'(get_out(k)), 32'(e_out[k]));
        chk("frame_err", k, 32'(fe[k]), 32'(e_fe[k]));
        chk("parity_err", k, 32'(pe[k]), 32'(e_pe[k]));
        chk("overrun_err", k, 32'(oe[k]), 32'(e_oe[k]));
        chk("busy", k, 32'(bsy[k]), 32'(m_inf[k]));
        if (rdy[k] === 1'b1 && rdy_prev[k] === 1'b0) rise_cyc[k] = cyc;
      end
      rdy_prev = rdy;
    end
  end

  task automatic send_frame(input int k, input logic [8:0] data, input bit bad_par,
                            input bit stop_low, input int hold_low);
    logic [15:0] bits;
    int nb;
    bits = '0;
    nb = 1;
    for (int i = 0; i < f_db(k); i++) begin bits[nb] = data[i]; nb++; end
    if (PEN == 1) begin
      bits[nb] = (^(data & 9'((1 << f_db(k)) - 1))) ^ f_po(k) ^ bad_par;
      nb++;
    end
    for (int i = 0; i < f_sb(k); i++) begin bits[nb] = !stop_low; nb++; end
    start_cyc[k] = cyc;
    for (int i = 0; i < nb; i++) begin
      rxi[k] = bits[i];
      repeat (f_os(k) * rate[k]) @(negedge clk);
    end
    repeat (hold_low) @(negedge clk);
    rxi[k] = 1'b1;
    repeat (20 * rate[k]) @(negedge clk);
  endtask

  task automatic pulse_clr(input int k);
    clr[k] = 1'b1;
    @(negedge clk);
    clr[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst = '1; rxi = '1; clr = '0;
    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", k, 32'(rdy[k]), 32'd0);
      chk("reset_rx_out", k, 32'(get_out(k)), 32'd0);
    end
    repeat (5) @(negedge clk);

    // Clean 8N1 frame and its absolute latency from the falling start edge.
    send_frame(0, 9'h0A5, 0, 0, 0);
    chk("clean_out", 0, 32'(out0), 32'hA5);
    chk("clean_flags", 0, {29'd0, fe[0], pe[0], oe[0]}, 32'd0);
    chk("clean_busy", 0, 32'(bsy[0]), 32'd0);
    chk("lat_8n1", 0, 32'(rise_cyc[0] - start_cyc[0]), 32'd155 + 32'(16 * PEN));
    pulse_clr(0);
    chk("clr_ready", 0, 32'(rdy[0]), 32'd0);

    // Short low glitch on an idle line.
    rxi[0] = 1'b0;
    repeat (5) @(negedge clk);
    rxi[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", 0, 32'(bsy[0]), 32'd0);
    chk("glitch_ready", 0, 32'(rdy[0]), 32'd0);

    // Framing error followed by a break.
    send_frame(0, 9'h03C, 0, 1, 40);
    chk("break_fe", 0, 32'(fe[0]), 32'd1);
    chk("break_out", 0, 32'(out0), 32'h3C);
    pulse_clr(0);

    // Overrun: second word lands while ready is still set.
    send_frame(0, 9'h011, 0, 0, 0);
    send_frame(0, 9'h022, 0, 0, 0);
    chk("overrun_out", 0, 32'(out0), 32'h22);
    chk("overrun_oe", 0, 32'(oe[0]), 32'd1);
    pulse_clr(0);

    // ready_clr in the very cycle of delivery: set wins, no overrun.
    send_frame(0, 9'h05A, 0, 0, 0);
    fork
      send_frame(0, 9'h0C3, 0, 0, 0);
      begin
        repeat (154 + 16 * PEN) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
      end
    join
    chk("coinc_ready", 0, 32'(rdy[0]), 32'd1);
    chk("coinc_oe", 0, 32'(oe[0]), 32'd0);
    chk("coinc_out", 0, 32'(out0), 32'hC3);
    pulse_clr(0);

`ifdef UART_RX_PARITY_EN
    send_frame(0, 9'h007, 1, 0, 0);
    chk("parity_bad", 0, 32'(pe[0]), 32'd1);
    pulse_clr(0);
    send_frame(0, 9'h007, 0, 0, 0);
    chk("parity_good", 0, 32'(pe[0]), 32'd0);
    pulse_clr(0);
`endif

    // Randomised frames on the 8-bit receiver.
    for (int f = 0; f < 20; f++) begin
      send_frame(0, 9'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 0);
      repeat ($urandom_range(2, 30)) begin
        clr[0] = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      clr[0] = 1'b0;
    end

    // 5-bit, 2 stop bits: full rate, then one tick every third cycle.
    send_frame(1, 9'h015, 0, 0, 0);
    chk("u1_out_full", 1, 32'(out1), 32'h15);
    chk("lat_5n2", 1, 32'(rise_cyc[1] - start_cyc[1]), 32'd123 + 32'(16 * PEN));
    pulse_clr(1);
    rate[1] = 3;
    repeat (6) @(negedge clk);
    send_frame(1, 9'h015, 0, 0, 0);
    chk("u1_out_slow", 1, 32'(out1), 32'h15);
    lat = rise_cyc[1] - start_cyc[1] - 3 * 16 * PEN;
    chk("lat_slow_range", 1, 32'(lat >= 361 && lat <= 367), 32'd1);
    pulse_clr(1);

    // Reset in the middle of the data bits discards the frame.
    rxi[1] = 1'b0;
    repeat (48) @(negedge clk);
    rxi[1] = 1'b1;
    repeat (48) @(negedge clk);
    rxi[1] = 1'b0;
    repeat (24) @(negedge clk);
    chk("mid_data_busy", 1, 32'(bsy[1]), 32'd1);
    rst[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst[1] = 1'b0;
    rxi[1] = 1'b1;
    repeat (300) @(negedge clk);
    chk("reset_drop_ready", 1, 32'(rdy[1]), 32'd0);
    chk("reset_drop_fe", 1, 32'(fe[1]), 32'd0);

    // Randomised 9-bit frames at a non-power-of-two oversample ratio.
    for (int f = 0; f < 12; f++) begin
      rate[2] = $urandom_range(1, 2);
      repeat (4) @(negedge clk);
      send_frame(2, 9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), 0);
      repeat ($urandom_range(2, 20)) begin
        clr[2] = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
      clr[2] = 1'b0;
    end

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
